// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with several chip selects, all four clock
// modes and a programmable SCLK divider.
//
// Ports:
//   clk, rst_n   system clock (rising edge) and synchronous active-low reset
//   ena          block enable; dropping it mid-transfer aborts the transfer
//   start        transfer request, only looked at in IDLE
//   tx_data      word to shift out, MSB first
//   cs_sel       index of the slave to select
//   cpol, cpha   SPI clock polarity / phase for the requested transfer
//   clk_div      SCLK half-period is clk_div+1 clk cycles
//   miso         serial data from the slave
//   sclk, mosi   SPI clock and serial data to the slave
//   cs_n         active-low chip selects, one low during a transfer
//   busy         high from LEAD through TRAIL
//   done         one-cycle pulse in the first idle cycle after a transfer
//   rx_data      last word received, updated with done
//   err          one-cycle pulse when start names a non-existent slave
//   state_dbg    current FSM state (IDLE=0, LEAD=1, XFER=2, TRAIL=3)
//
// Handshake: a request is taken when ena=1 and start=1 on a clock edge where
// the FSM is in IDLE (including the cycle done=1); at any other time start is
// ignored. Every accepted transfer ends with exactly one of done (completed),
// an abort (ena low, no done) or reset (no done).
module spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int CS_NUM = 2,
    parameter int DIV_W  = 8,
    localparam int SEL_W = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [CS_NUM-1:0] cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              err,
    output logic [1:0]        state_dbg
);
    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES + 1);
    localparam logic [SEL_W:0] CS_LIM    = (SEL_W + 1)'(CS_NUM);
    localparam logic [EW-1:0]  LAST_EDGE = EW'(EDGES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    div_lat_q, div_lat_d;
    logic [EW-1:0]       edge_q, edge_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CS_NUM-1:0]   cs_n_q, cs_n_d;
    logic                fire_edge;
    logic                lead_edge;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        div_lat_d = div_lat_q;
        edge_d    = edge_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_d      = rx_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        cs_n_d    = cs_n_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fire_edge = 1'b0;
        lead_edge = 1'b0;

        // Every non-idle state is a whole number of half-periods.
        if (state_q != IDLE) begin
            div_d = (div_q == '0) ? div_lat_q : div_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ena && start) begin
                    if ({1'b0, cs_sel} < CS_LIM) begin
                        state_d   = LEAD;
                        busy_d    = 1'b1;
                        cpol_d    = cpol;
                        cpha_d    = cpha;
                        div_lat_d = clk_div;
                        div_d     = clk_div;
                        edge_d    = '0;
                        sclk_d    = cpol;
                        cs_n_d    = '1;
                        for (int i = 0; i < CS_NUM; i++) begin
                            if (i == int'(cs_sel)) cs_n_d[i] = 1'b0;
                        end
                        // cpha=0 presents the MSB for the whole of LEAD; cpha=1
                        // drives it on the first leading edge instead.
                        if (cpha) begin
                            mosi_d  = 1'b0;
                            tx_sh_d = tx_data;
                        end else begin
                            mosi_d  = tx_data[DATA_W-1];
                            tx_sh_d = {tx_data[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LEAD: begin
                if (div_q == '0) begin
                    state_d   = XFER;
                    fire_edge = 1'b1;
                end
            end
            XFER: begin
                // The 2*DATA_W edges sit at the start of each XFER half-period,
                // so the last half-period is already back at cpol.
                if (div_q == '0) begin
                    if (edge_q == LAST_EDGE) state_d = TRAIL;
                    else                     fire_edge = 1'b1;
                end
            end
            TRAIL: begin
                if (div_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rx_d    = rx_sh_q;
                    cs_n_d  = '1;
                    mosi_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cs_n_d  = '1;
                mosi_d  = 1'b0;
                sclk_d  = cpol_q;
            end
        endcase

        if (fire_edge) begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + 1'b1;
            // Odd-numbered edges (edge_q even before this one) are leading.
            lead_edge = ~edge_q[0];
            if (lead_edge == cpha_q) begin
                mosi_d  = tx_sh_q[DATA_W-1];
                tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
            end else begin
                rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
            end
        end

        // Abort wins over everything the transfer would otherwise do.
        if ((state_q != IDLE) && !ena) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            rx_d    = rx_q;
            cs_n_d  = '1;
            mosi_d  = 1'b0;
            sclk_d  = cpol_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            div_lat_q <= '0;
            edge_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_q      <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cs_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            div_lat_q <= div_lat_d;
            edge_q    <= edge_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_q      <= rx_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rx_data   = rx_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi. CS_NUM=3 so that a two-bit cs_sel can name a
// slave that does not exist (index 3).
module tb_spi_master_multi;
    localparam int DW  = 8;
    localparam int CSN = 3;
    localparam int DVW = 8;
    localparam int SW  = 2;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b0;
    logic           start = 1'b0;
    logic [DW-1:0]  tx_data = '0;
    logic [SW-1:0]  cs_sel = '0;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic [DVW-1:0] clk_div = '0;
    logic           miso;
    logic           sclk, mosi, busy, done, err;
    logic [CSN-1:0] cs_n;
    logic [DW-1:0]  rx_data;
    logic [1:0]     state_dbg;

    always #5 clk = ~clk;

    spi_master_multi #(.DATA_W(DW), .CS_NUM(CSN), .DIV_W(DVW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .tx_data(tx_data),
        .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .miso(miso),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done),
        .rx_data(rx_data), .err(err), .state_dbg(state_dbg)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- miso source: slave model / loopback / tied high ----------------
    int            miso_mode = 0;   // 0 slave, 1 loopback, 2 constant 1
    logic [DW-1:0] slv_word = '0;
    logic [DW-1:0] slv_sr = '0;
    logic          slv_miso = 1'b0;
    logic          slv_sel = 1'b0;
    logic          slv_sclk = 1'b0;

    assign miso = (miso_mode == 1) ? mosi : (miso_mode == 2) ? 1'b1 : slv_miso;

    // ---------------- behavioural model of the transfer ----------------
    bit            model_valid = 0;
    bit            m_active = 0;
    int            m_t = 0, m_h = 1, m_n = 1;
    logic          m_cpol = 1'b0, m_cpha = 1'b0, m_idle_cpol = 1'b0;
    logic [SW-1:0] m_sel = '0;
    logic [DW-1:0] m_tx = '0, m_rx = '0, m_rx_next = '0;
    logic          m_done = 1'b0, m_err = 1'b0;

    // A slave that loads slv_word on select, and shifts out on the edge
    // opposite to the master's sampling edge.
    always @(negedge clk) begin
        if (&cs_n) begin
            slv_sel = 1'b0;
        end else if (!slv_sel) begin
            slv_sel = 1'b1;
            slv_sr  = slv_word;
            if (!m_cpha) begin
                slv_miso = slv_sr[DW-1];
                slv_sr   = {slv_sr[DW-2:0], 1'b0};
            end
        end else if (sclk !== slv_sclk) begin
            if ((slv_sclk == m_cpol) == m_cpha) begin
                slv_miso = slv_sr[DW-1];
                slv_sr   = {slv_sr[DW-2:0], 1'b0};
            end
        end
        slv_sclk = sclk;
    end

    // Model: a transfer is just a cycle count t = 1..N with N = (2*DW+2)*H.
    always @(posedge clk) begin
        cyc++;
        model_valid = 1;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rst_n) begin
            m_active    = 0;
            m_rx        = '0;
            m_idle_cpol = 1'b0;
        end else if (m_active) begin
            if (!ena) begin
                m_active = 0;
            end else if (m_t == m_n) begin
                m_active = 0;
                m_done   = 1'b1;
                m_rx     = m_rx_next;
            end else begin
                m_t++;
            end
        end else if (ena && start) begin
            if (int'(cs_sel) < CSN) begin
                m_active    = 1;
                m_t         = 1;
                m_h         = int'(clk_div) + 1;
                m_n         = (2 * DW + 2) * m_h;
                m_cpol      = cpol;
                m_cpha      = cpha;
                m_sel       = cs_sel;
                m_tx        = tx_data;
                m_idle_cpol = cpol;
                m_rx_next   = (miso_mode == 1) ? tx_data : (miso_mode == 2) ? '1 : slv_word;
            end else begin
                m_err = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare + statistics ----------------
    int             hp, ne;
    logic           e_sclk;
    logic [CSN-1:0] e_cs;
    logic           prev_busy = 1'b0;
    logic           prev_sclk = 1'b0;
    int             busy_run = 0, last_busy_len = 0;
    int             done_cnt = 0, err_cnt = 0, last_done_cyc = 0;
    logic [CSN-1:0] last_cs_n = '1;
    logic [DW-1:0]  cap = '0;

    always @(negedge clk) begin
        if (model_valid) begin
            if (m_active) begin
                hp = (m_t - 1) / m_h;                           // half-period index 0..2*DW+1
                ne = (hp == 0) ? 0 : ((hp > 2 * DW) ? 2 * DW : hp); // edges so far
                e_sclk = m_cpol ^ ne[0];
                e_cs = ~(CSN'(1) << m_sel);
                chk("busy", busy, 1);
                chk("cs_n", cs_n, e_cs);
                chk("sclk", sclk, e_sclk);
                if (!m_cpha && hp <= 2 * DW - 1)
                    chk("mosi", mosi, m_tx[DW-1-hp/2]);
                else if (m_cpha && hp >= 1 && hp <= 2 * DW)
                    chk("mosi", mosi, m_tx[DW-1-(hp-1)/2]);
            end else begin
                chk("busy_idle", busy, 0);
                chk("cs_n_idle", cs_n, {CSN{1'b1}});
                chk("sclk_idle", sclk, m_idle_cpol);
                chk("mosi_idle", mosi, 0);
            end
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("rx_data", rx_data, m_rx);

            if (busy === 1'b1) begin
                if (!prev_busy) cap = '0;
                busy_run++;
                last_cs_n = cs_n;
                if (prev_busy && sclk !== prev_sclk && ((prev_sclk == m_cpol) != m_cpha))
                    cap = {cap[DW-2:0], mosi};
            end else begin
                if (prev_busy) last_busy_len = busy_run;
                busy_run = 0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (err === 1'b1) err_cnt++;
            prev_busy = busy;
            prev_sclk = sclk;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_xfer(input logic [DW-1:0] tx, input logic [SW-1:0] sel,
                              input logic pol, input logic pha, input logic [DVW-1:0] div,
                              input int mm, input logic [DW-1:0] sw);
        @(negedge clk);
        miso_mode = mm;
        slv_word  = sw;
        tx_data   = tx;
        cs_sel    = sel;
        cpol      = pol;
        cpha      = pha;
        clk_div   = div;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble the request inputs; the transfer must not notice.
        tx_data = ~tx;
        cs_sel  = 2'd3;
        cpol    = ~pol;
        cpha    = ~pha;
        clk_div = ~div;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < lim);
        chk("done_seen", done, 1);
        #1;
    endtask

    // ---------------- directed tests ----------------
    int d0, e0, t1;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cs_n", cs_n, 3'b111);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_rx", rx_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Mode 0, clk/2, loopback, slave 1.
        d0 = done_cnt;
        start_xfer(8'hA5, 2'd1, 1'b0, 1'b0, 8'd0, 1, 8'h00);
        wait_done(100);
        chk("t1_busy_len", last_busy_len, 18);
        chk("t1_cs_n", last_cs_n, 3'b101);
        chk("t1_rx", rx_data, 8'hA5);
        chk("t1_mosi_bits", cap, 8'hA5);
        chk("t1_done_cnt", done_cnt - d0, 1);

        // Mode 3, clk_div=1, miso tied high.
        start_xfer(8'h3C, 2'd0, 1'b1, 1'b1, 8'd1, 2, 8'h00);
        wait_done(200);
        chk("t2_busy_len", last_busy_len, 36);
        chk("t2_mosi_bits", cap, 8'h3C);
        chk("t2_rx", rx_data, 8'hFF);
        @(negedge clk);
        chk("t2_sclk_idle", sclk, 1);

        // Mode 1 and mode 2 against a slave returning 0x5A.
        start_xfer(8'h96, 2'd2, 1'b0, 1'b1, 8'd2, 0, 8'h5A);
        wait_done(300);
        chk("t3_mode1_rx", rx_data, 8'h5A);
        chk("t3_mode1_len", last_busy_len, 54);
        start_xfer(8'h69, 2'd0, 1'b1, 1'b0, 8'd0, 0, 8'h5A);
        wait_done(100);
        chk("t3_mode2_rx", rx_data, 8'h5A);

        // Start pulsed mid-transfer is ignored.
        d0 = done_cnt;
        start_xfer(8'hC3, 2'd1, 1'b0, 1'b0, 8'd0, 0, 8'h3C);
        repeat (3) @(negedge clk);
        tx_data = 8'h00;
        cs_sel  = 2'd0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        chk("t4_rx", rx_data, 8'h3C);
        repeat (40) @(negedge clk);
        chk("t4_single_done", done_cnt - d0, 1);

        // Invalid slave index: err pulse, nothing else moves.
        e0 = err_cnt;
        @(negedge clk);
        cs_sel = 2'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_err", err, 1);
        chk("t4_err_busy", busy, 0);
        chk("t4_err_cs_n", cs_n, 3'b111);
        @(negedge clk);
        chk("t4_err_cnt", err_cnt - e0, 1);

        // ena dropped mid-XFER: abort, no done, rx held; start with ena=0 ignored.
        d0 = done_cnt;
        start_xfer(8'hF0, 2'd0, 1'b0, 1'b0, 8'd0, 0, 8'h99);
        repeat (6) @(negedge clk);
        ena   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_cs_n", cs_n, 3'b111);
        @(negedge clk);
        start = 1'b0;
        ena   = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_rx_held", rx_data, 8'h3C);

        // Reset mid-transfer.
        d0 = done_cnt;
        start_xfer(8'h55, 2'd1, 1'b1, 1'b0, 8'd3, 1, 8'h00);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cs_n", cs_n, 3'b111);
        chk("t5_rst_sclk", sclk, 0);
        chk("t5_rst_rx", rx_data, 0);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("t5_rst_no_done", done_cnt - d0, 0);

        // Back-to-back with start held high: 0x81 then 0x7E.
        @(negedge clk);
        miso_mode = 1;
        tx_data   = 8'h81;
        cs_sel    = 2'd1;
        cpol      = 1'b0;
        cpha      = 1'b0;
        clk_div   = 8'd0;
        start     = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (busy !== 1'b1 && n < 10);
            chk("t6_first_busy", busy, 1);
        end
        tx_data = 8'h7E;
        wait_done(100);
        t1 = last_done_cyc;
        chk("t6_rx1", rx_data, 8'h81);
        @(negedge clk);
        chk("t6_second_busy", busy, 1);
        start = 1'b0;
        wait_done(100);
        // 18 busy cycles sit between the two done pulses.
        chk("t6_done_gap", last_done_cyc - t1, 19);
        chk("t6_rx2", rx_data, 8'h7E);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
